// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI transfer arbiter.
package spi_pkg;

    localparam int SPI_NREQ         = 4;
    localparam int SPI_TIMEOUT      = 256;
    localparam int SPI_DWIDTH       = 32;
    localparam int SPI_AWIDTH       = 12;
    localparam int SPI_S_ADDR_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: the search starts just after the last grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
)(
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last_grant,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_valid
);

    int w_pos;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_pos       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = int'(i_last_grant) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (!o_valid && i_req[IW'(w_pos)]) begin
                o_valid              = 1'b1;
                o_grant_idx          = IW'(w_pos);
                o_grant[IW'(w_pos)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master among NREQ requesters, one transfer outstanding at a time.
// state | meaning: IDLE grant+latch | ISSUE m_start pulse | WAIT for m_done/timeout | RESP completion pulse
module spi_xfer_arbiter #(
    parameter int NREQ         = spi_pkg::SPI_NREQ,
    parameter int TIMEOUT      = spi_pkg::SPI_TIMEOUT,
    parameter int DWIDTH       = spi_pkg::SPI_DWIDTH,
    parameter int AWIDTH       = spi_pkg::SPI_AWIDTH,
    parameter int S_ADDR_WIDTH = spi_pkg::SPI_S_ADDR_WIDTH
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ-1:0]                     req_wr,
    input  logic [NREQ-1:0][S_ADDR_WIDTH-1:0]   req_slave,
    input  logic [NREQ-1:0][AWIDTH-1:0]         req_addr,
    input  logic [NREQ-1:0][DWIDTH-1:0]         req_wdata,
    output logic [NREQ-1:0]                     resp_valid,
    output logic [DWIDTH-1:0]                   resp_rdata,
    output logic                                resp_err,
    output logic                                m_start,
    output logic                                m_wr,
    output logic [S_ADDR_WIDTH-1:0]             m_slave,
    output logic [AWIDTH-1:0]                   m_addr,
    output logic [DWIDTH-1:0]                   m_wdata,
    input  logic                                m_done,
    input  logic [DWIDTH-1:0]                   m_rdata
);

    import spi_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

    state_t                    r_state;
    logic [IW-1:0]             r_last_grant;
    logic [IW-1:0]             r_grant;
    logic [CW-1:0]             r_tmo_cnt;
    logic                      r_m_start;
    logic                      r_m_wr;
    logic [S_ADDR_WIDTH-1:0]   r_m_slave;
    logic [AWIDTH-1:0]         r_m_addr;
    logic [DWIDTH-1:0]         r_m_wdata;
    logic [NREQ-1:0]           r_resp_valid;
    logic [DWIDTH-1:0]         r_resp_rdata;
    logic                      r_resp_err;

    logic [NREQ-1:0]           w_grant_oh;
    logic [IW-1:0]             w_grant_idx;
    logic                      w_grant_vld;
    logic [NREQ-1:0]           w_owner_oh;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_valid      (w_grant_vld)
    );

    assign w_owner_oh = NREQ'(1) << r_grant;

    // Ready is the live grant, so a request dropped before acceptance simply loses its turn.
    assign req_ready  = (r_state == ST_IDLE) ? w_grant_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= LAST_INIT;
            r_grant      <= '0;
            r_tmo_cnt    <= '0;
            r_m_start    <= 1'b0;
            r_m_wr       <= 1'b0;
            r_m_slave    <= '0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_m_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_grant   <= w_grant_idx;
                        r_m_wr    <= req_wr[w_grant_idx];
                        r_m_slave <= req_slave[w_grant_idx];
                        r_m_addr  <= req_addr[w_grant_idx];
                        r_m_wdata <= req_wdata[w_grant_idx];
                        r_m_start <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the final timeout cycle still counts as success.
                    if (m_done) begin
                        r_resp_rdata <= m_rdata;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= w_owner_oh;
                        r_state      <= ST_RESP;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= w_owner_oh;
                        r_state      <= ST_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= '0;
                    r_resp_err   <= 1'b0;
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_start    = r_m_start;
    assign m_wr       = r_m_wr;
    assign m_slave    = r_m_slave;
    assign m_addr     = r_m_addr;
    assign m_wdata    = r_m_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
